// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory-port arbiter: default widths, requester IDs
// and the port FSM state encoding.
package mem_port_arbiter_pkg;

    localparam int WORD_SIZE = 16;
    localparam int ADDR_SIZE = 16;

    // Requester IDs double as bit positions in the req/gnt vectors.
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR      = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RD_CAP  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick. A lone requester wins outright; on
// a tie the requester that was not served last wins. Output is one-hot or 0.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o
);
    import mem_port_arbiter_pkg::*;

    // Tie goes to whoever did not hold the port last.
    always_comb begin
        gnt_o = 2'b00;
        if (&req_i) begin
            if (last_grant_i == REQ_DBG) gnt_o[REQ_CPU] = 1'b1;
            else                         gnt_o[REQ_DBG] = 1'b1;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between the CPU core and the debug /
// loader port. One transaction in flight at a time, all outputs registered.
module mem_port_arbiter #(
    parameter int WORD_SIZE  = mem_port_arbiter_pkg::WORD_SIZE,
    parameter int ADDR_SIZE  = mem_port_arbiter_pkg::ADDR_SIZE,
    parameter int RD_LATENCY = 1
) (
    input  logic                 DCLK,
    input  logic                 RSTn,
    input  logic                 CPU_REQ,
    input  logic                 CPU_WE,
    input  logic [ADDR_SIZE-1:0] CPU_ADDR,
    input  logic [WORD_SIZE-1:0] CPU_WDATA,
    output logic                 CPU_GNT,
    output logic                 CPU_RVALID,
    output logic [WORD_SIZE-1:0] CPU_RDATA,
    input  logic                 DBG_REQ,
    input  logic                 DBG_WE,
    input  logic [ADDR_SIZE-1:0] DBG_ADDR,
    input  logic [WORD_SIZE-1:0] DBG_WDATA,
    output logic                 DBG_GNT,
    output logic                 DBG_RVALID,
    output logic [WORD_SIZE-1:0] DBG_RDATA,
    input  logic                 DBG_HOLD,
    output logic                 M_W,
    output logic [ADDR_SIZE-1:0] MADDR,
    output logic [WORD_SIZE-1:0] MDATAOUT,
    input  logic [WORD_SIZE-1:0] MDATAIN,
    output logic                 BUSY
);
    import mem_port_arbiter_pkg::*;

    localparam int CNT_W = $clog2(RD_LATENCY + 1);

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 last_q;   // requester served most recently
    logic                 owner_q;  // requester owning the in-flight read
    logic                 cpu_gnt_q, dbg_gnt_q, cpu_rvalid_q, dbg_rvalid_q;
    logic                 m_w_q, busy_q;
    logic [ADDR_SIZE-1:0] maddr_q;
    logic [WORD_SIZE-1:0] mdataout_q, cpu_rdata_q, dbg_rdata_q;

    logic [1:0]           elig, pick;
    logic                 arb_en;
    logic                 we_d;
    logic [ADDR_SIZE-1:0] addr_d;
    logic [WORD_SIZE-1:0] wdata_d;

    // DBG_HOLD only masks the CPU; the debug port is always eligible.
    assign elig[REQ_CPU] = CPU_REQ & ~DBG_HOLD;
    assign elig[REQ_DBG] = DBG_REQ;

    rr_arb2 u_arb (
        .req_i        (elig),
        .last_grant_i (last_q),
        .gnt_o        (pick)
    );

    // The capture edge of a read also arbitrates, giving back-to-back reads.
    assign arb_en  = (state_q == ST_IDLE) || (state_q == ST_RD_CAP);
    assign we_d    = pick[REQ_DBG] ? DBG_WE    : CPU_WE;
    assign addr_d  = pick[REQ_DBG] ? DBG_ADDR  : CPU_ADDR;
    assign wdata_d = pick[REQ_DBG] ? DBG_WDATA : CPU_WDATA;

    // Port FSM: pulses default low, a grant overrides the return to IDLE.
    always_ff @(posedge DCLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_q       <= REQ_DBG;
            owner_q      <= REQ_CPU;
            cpu_gnt_q    <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            m_w_q        <= 1'b0;
            busy_q       <= 1'b0;
            maddr_q      <= '0;
            mdataout_q   <= '0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            cpu_gnt_q    <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            m_w_q        <= 1'b0;
            case (state_q)
                ST_WR: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                ST_RD_WAIT: begin
                    if (cnt_q <= CNT_W'(1)) state_q <= ST_RD_CAP;
                    else                    cnt_q   <= cnt_q - CNT_W'(1);
                end
                ST_RD_CAP: begin
                    if (owner_q == REQ_DBG) begin
                        dbg_rdata_q  <= MDATAIN;
                        dbg_rvalid_q <= 1'b1;
                    end else begin
                        cpu_rdata_q  <= MDATAIN;
                        cpu_rvalid_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: ;
            endcase
            if (arb_en && (|pick)) begin
                cpu_gnt_q  <= pick[REQ_CPU];
                dbg_gnt_q  <= pick[REQ_DBG];
                owner_q    <= pick[REQ_DBG];
                last_q     <= pick[REQ_DBG];
                maddr_q    <= addr_d;
                mdataout_q <= wdata_d;
                m_w_q      <= we_d;
                cnt_q      <= CNT_W'(RD_LATENCY);
                state_q    <= we_d ? ST_WR : ST_RD_WAIT;
                busy_q     <= 1'b1;
            end
        end
    end

    assign CPU_GNT    = cpu_gnt_q;
    assign DBG_GNT    = dbg_gnt_q;
    assign CPU_RVALID = cpu_rvalid_q;
    assign DBG_RVALID = dbg_rvalid_q;
    assign CPU_RDATA  = cpu_rdata_q;
    assign DBG_RDATA  = dbg_rdata_q;
    assign M_W        = m_w_q;
    assign MADDR      = maddr_q;
    assign MDATAOUT   = mdataout_q;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a one-cycle-latency memory model.
module tb_mem_port_arbiter;

    localparam int WS = 16;
    localparam int AS = 16;

    logic          DCLK = 1'b0;
    logic          RSTn;
    logic          CPU_REQ, CPU_WE, DBG_REQ, DBG_WE, DBG_HOLD;
    logic [AS-1:0] CPU_ADDR, DBG_ADDR, MADDR;
    logic [WS-1:0] CPU_WDATA, DBG_WDATA, MDATAOUT, MDATAIN;
    logic [WS-1:0] CPU_RDATA, DBG_RDATA;
    logic          CPU_GNT, CPU_RVALID, DBG_GNT, DBG_RVALID, M_W, BUSY;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .RD_LATENCY(1)) dut (
        .DCLK(DCLK), .RSTn(RSTn),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
        .CPU_GNT(CPU_GNT), .CPU_RVALID(CPU_RVALID), .CPU_RDATA(CPU_RDATA),
        .DBG_REQ(DBG_REQ), .DBG_WE(DBG_WE), .DBG_ADDR(DBG_ADDR), .DBG_WDATA(DBG_WDATA),
        .DBG_GNT(DBG_GNT), .DBG_RVALID(DBG_RVALID), .DBG_RDATA(DBG_RDATA),
        .DBG_HOLD(DBG_HOLD), .M_W(M_W), .MADDR(MADDR), .MDATAOUT(MDATAOUT),
        .MDATAIN(MDATAIN), .BUSY(BUSY)
    );

    always #5 DCLK = ~DCLK;

    // Synchronous memory: registered read, one cycle after the address cycle.
    logic [WS-1:0] mem [0:65535];
    logic          poke_en = 1'b0;
    logic [AS-1:0] poke_a  = '0;
    logic [WS-1:0] poke_d  = '0;
    always @(posedge DCLK) begin
        if (poke_en)  mem[poke_a] <= poke_d;
        else if (M_W) mem[MADDR]  <= MDATAOUT;
        MDATAIN <= mem[MADDR];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge DCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [AS-1:0] a, input logic [WS-1:0] d);
        poke_en = 1'b1; poke_a = a; poke_d = d;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic clear_inputs();
        CPU_REQ = 0; CPU_WE = 0; CPU_ADDR = '0; CPU_WDATA = '0;
        DBG_REQ = 0; DBG_WE = 0; DBG_ADDR = '0; DBG_WDATA = '0;
        DBG_HOLD = 0;
    endtask

    task automatic do_reset();
        RSTn = 0;
        clear_inputs();
        tick(); tick();
        RSTn = 1;
    endtask

    int cpu_seen;

    initial begin
        // ---- reset with both requesters asserting, then first grant
        RSTn = 0;
        clear_inputs();
        CPU_REQ = 1; CPU_ADDR = 16'h0005;
        DBG_REQ = 1; DBG_ADDR = 16'h0002;
        poke(16'h0005, 16'h1234);
        poke(16'h0002, 16'hB002);
        poke(16'h0001, 16'hC001);
        chk("rst_cpu_gnt", CPU_GNT, 0);
        chk("rst_dbg_gnt", DBG_GNT, 0);
        chk("rst_m_w", M_W, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_maddr", MADDR, 0);
        chk("rst_rvalid", {CPU_RVALID, DBG_RVALID}, 0);
        chk("rst_rdata", {CPU_RDATA, DBG_RDATA}, 0);
        RSTn = 1;

        // ---- CPU wins first contention, read of 0x0005
        tick();
        chk("a_cpu_gnt", CPU_GNT, 1);
        chk("a_dbg_gnt", DBG_GNT, 0);
        chk("a_maddr", MADDR, 16'h0005);
        chk("a_m_w", M_W, 0);
        chk("a_busy", BUSY, 1);
        CPU_REQ = 0;
        tick();
        chk("a_gnt_pulse", CPU_GNT, 0);
        chk("a_rvalid_early", CPU_RVALID, 0);
        tick();
        chk("a_cpu_rvalid", CPU_RVALID, 1);
        chk("a_cpu_rdata", CPU_RDATA, 16'h1234);
        chk("a_dbg_rvalid0", DBG_RVALID, 0);
        chk("a_dbg_gnt_b2b", DBG_GNT, 1);
        chk("a_maddr_dbg", MADDR, 16'h0002);
        DBG_REQ = 0;
        tick();
        chk("a_cpu_rvalid_pulse", CPU_RVALID, 0);
        tick();
        chk("a_dbg_rvalid", DBG_RVALID, 1);
        chk("a_dbg_rdata", DBG_RDATA, 16'hB002);
        chk("a_cpu_rdata_hold", CPU_RDATA, 16'h1234);
        chk("a_busy_idle", BUSY, 0);
        tick();
        chk("a_maddr_hold", MADDR, 16'h0002);

        // ---- contention: CPU write vs DBG read of the same word
        do_reset();
        CPU_REQ = 1; CPU_WE = 1; CPU_ADDR = 16'h0010; CPU_WDATA = 16'hAAAA;
        DBG_REQ = 1; DBG_WE = 0; DBG_ADDR = 16'h0010;
        tick();
        chk("b_cpu_gnt", CPU_GNT, 1);
        chk("b_dbg_gnt0", DBG_GNT, 0);
        chk("b_m_w", M_W, 1);
        chk("b_mdataout", MDATAOUT, 16'hAAAA);
        chk("b_maddr", MADDR, 16'h0010);
        CPU_REQ = 0; CPU_WE = 0;
        tick();
        chk("b_m_w_off", M_W, 0);
        chk("b_busy_arb", BUSY, 0);
        chk("b_dbg_gnt_wait", DBG_GNT, 0);
        tick();
        chk("b_dbg_gnt", DBG_GNT, 1);
        chk("b_dbg_m_w", M_W, 0);
        DBG_REQ = 0;
        tick();
        tick();
        chk("b_dbg_rvalid", DBG_RVALID, 1);
        chk("b_dbg_rdata", DBG_RDATA, 16'hAAAA);
        chk("b_cpu_rvalid0", CPU_RVALID, 0);

        // ---- round-robin with both reading continuously
        do_reset();
        CPU_REQ = 1; CPU_ADDR = 16'h0001;
        DBG_REQ = 1; DBG_ADDR = 16'h0002;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("c_cpu_gnt", CPU_GNT, (i % 2 == 0));
            chk("c_dbg_gnt", DBG_GNT, (i % 2 == 1));
            chk("c_maddr", MADDR, (i % 2 == 0) ? 16'h0001 : 16'h0002);
            if (i > 0) begin
                if (i % 2 == 1) begin
                    chk("c_cpu_rvalid", CPU_RVALID, 1);
                    chk("c_cpu_rdata", CPU_RDATA, 16'hC001);
                end else begin
                    chk("c_dbg_rvalid", DBG_RVALID, 1);
                    chk("c_dbg_rdata", DBG_RDATA, 16'hB002);
                end
            end
            tick();
            chk("c_no_gnt", {CPU_GNT, DBG_GNT}, 0);
        end
        clear_inputs();

        // ---- DBG_HOLD locks the CPU off while a debug write goes through
        do_reset();
        DBG_HOLD = 1;
        CPU_REQ = 1; CPU_ADDR = 16'h0005;
        DBG_REQ = 1; DBG_WE = 1; DBG_ADDR = 16'h0003; DBG_WDATA = 16'h5555;
        tick();
        chk("d_dbg_gnt", DBG_GNT, 1);
        chk("d_cpu_gnt0", CPU_GNT, 0);
        chk("d_m_w", M_W, 1);
        chk("d_mdataout", MDATAOUT, 16'h5555);
        DBG_REQ = 0; DBG_WE = 0;
        cpu_seen = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (CPU_GNT) cpu_seen++;
        end
        chk("d_no_cpu_gnt", cpu_seen, 0);
        chk("d_busy_idle", BUSY, 0);
        chk("d_mem_written", mem[16'h0003], 16'h5555);
        DBG_HOLD = 0;
        tick();
        chk("d_cpu_gnt", CPU_GNT, 1);
        chk("d_cpu_maddr", MADDR, 16'h0005);
        CPU_REQ = 0;
        tick();
        tick();
        chk("d_cpu_rvalid", CPU_RVALID, 1);
        chk("d_cpu_rdata", CPU_RDATA, 16'h1234);

        // ---- reset while a read is in RD_WAIT
        do_reset();
        CPU_REQ = 1; CPU_ADDR = 16'h0005;
        tick();
        chk("e_cpu_gnt", CPU_GNT, 1);
        CPU_REQ = 0;
        RSTn = 0;
        #1;
        chk("e_busy_rst", BUSY, 0);
        chk("e_m_w_rst", M_W, 0);
        chk("e_gnt_rst", CPU_GNT, 0);
        tick();
        chk("e_no_rvalid1", CPU_RVALID, 0);
        tick();
        chk("e_no_rvalid2", CPU_RVALID, 0);
        chk("e_rdata_rst", CPU_RDATA, 0);
        RSTn = 1;
        CPU_REQ = 1; CPU_ADDR = 16'h0003;
        tick();
        chk("e_cpu_gnt2", CPU_GNT, 1);
        CPU_REQ = 0;
        tick();
        tick();
        chk("e_cpu_rvalid", CPU_RVALID, 1);
        chk("e_cpu_rdata", CPU_RDATA, 16'h5555);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
